alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_alu_arbiter.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a shared combinational ALU.
// Grants one operation at a time (fixed priority or round-robin) and returns the result over a valid/ready response.
module alu_arbiter #(
  parameter int unsigned RR_EN = 1
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_inp_1,
  input  logic [31:0] req0_inp_2,
  input  logic [3:0]  req0_sel,

  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_inp_1,
  input  logic [31:0] req1_inp_2,
  input  logic [3:0]  req1_sel,

  output logic [31:0] alu_inp_1,
  output logic [31:0] alu_inp_2,
  output logic [3:0]  alu_sel,
  input  logic [31:0] alu_result,
  input  logic        alu_overflow,

  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_result,
  output logic        rsp_overflow,
  output logic        rsp_err,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  localparam logic [3:0] SEL_MAX = 4'b1010;
  localparam logic [3:0] SEL_ADD = 4'b0101;
  localparam logic [3:0] SEL_SUB = 4'b0111;

  state_t      state;
  state_t      state_nxt;

  logic        last_id;
  logic        any_valid;
  logic        grant_id;
  logic        accept;

  logic [31:0] win_inp_1;
  logic [31:0] win_inp_2;
  logic [3:0]  win_sel;
  logic        win_legal;

  logic [31:0] alu_inp_1_q;
  logic [31:0] alu_inp_2_q;
  logic [3:0]  alu_sel_q;
  logic        rsp_id_q;
  logic [31:0] rsp_result_q;
  logic        rsp_overflow_q;
  logic        rsp_err_q;
  logic        ovf_op;

  // last_id resets to 1 so that requester 0 wins the first contested grant.
  always_comb begin
    any_valid = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
      grant_id = (RR_EN != 0) ? ~last_id : 1'b0;
    end else begin
      grant_id = req1_valid;
    end
  end

  assign accept     = (state == IDLE) && any_valid;
  assign req0_ready = accept && !grant_id;
  assign req1_ready = accept && grant_id;

  always_comb begin
    if (grant_id) begin
      win_inp_1 = req1_inp_1;
      win_inp_2 = req1_inp_2;
      win_sel   = req1_sel;
    end else begin
      win_inp_1 = req0_inp_1;
      win_inp_2 = req0_inp_2;
      win_sel   = req0_sel;
    end
    win_legal = (win_sel <= SEL_MAX);
  end

  assign ovf_op = (alu_sel_q == SEL_ADD) || (alu_sel_q == SEL_SUB);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = win_legal ? EXEC : RESP;
        end
      end
      EXEC: begin
        state_nxt = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ALU operand registers only load for legal opcodes, so an illegal request
  // leaves the shared ALU inputs untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_id        <= 1'b1;
      alu_inp_1_q    <= '0;
      alu_inp_2_q    <= '0;
      alu_sel_q      <= '0;
      rsp_id_q       <= 1'b0;
      rsp_result_q   <= '0;
      rsp_overflow_q <= 1'b0;
      rsp_err_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            rsp_id_q <= grant_id;
            if (win_legal) begin
              alu_inp_1_q <= win_inp_1;
              alu_inp_2_q <= win_inp_2;
              alu_sel_q   <= win_sel;
              rsp_err_q   <= 1'b0;
            end else begin
              rsp_result_q   <= '0;
              rsp_overflow_q <= 1'b0;
              rsp_err_q      <= 1'b1;
            end
          end
        end
        EXEC: begin
          rsp_result_q   <= alu_result;
          rsp_overflow_q <= alu_overflow && ovf_op;
        end
        RESP: begin
          if (rsp_ready) begin
            last_id <= rsp_id_q;
          end
        end
        default: begin
          last_id <= last_id;
        end
      endcase
    end
  end

  assign alu_inp_1    = alu_inp_1_q;
  assign alu_inp_2    = alu_inp_2_q;
  assign alu_sel      = alu_sel_q;
  assign rsp_valid    = (state == RESP);
  assign rsp_id       = rsp_id_q;
  assign rsp_result   = rsp_result_q;
  assign rsp_overflow = rsp_overflow_q;
  assign rsp_err      = rsp_err_q;
  assign busy         = (state != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a round-robin and a fixed-priority instance, each with its own ALU,
// driven by directed and random transactions against a transaction-level model.
module tb_alu_arbiter;

  logic clk;
  logic rst_n;

  logic        req0_valid [2];
  logic        req0_ready [2];
  logic [31:0] req0_inp_1 [2];
  logic [31:0] req0_inp_2 [2];
  logic [3:0]  req0_sel   [2];
  logic        req1_valid [2];
  logic        req1_ready [2];
  logic [31:0] req1_inp_1 [2];
  logic [31:0] req1_inp_2 [2];
  logic [3:0]  req1_sel   [2];
  logic [31:0] alu_inp_1  [2];
  logic [31:0] alu_inp_2  [2];
  logic [3:0]  alu_sel    [2];
  logic [31:0] alu_result [2];
  logic        alu_overflow [2];
  logic        rsp_valid  [2];
  logic        rsp_ready  [2];
  logic        rsp_id     [2];
  logic [31:0] rsp_result [2];
  logic        rsp_overflow [2];
  logic        rsp_err    [2];
  logic        busy       [2];

  int n_checks = 0;
  int n_errors = 0;

  // Model state per instance
  bit          rr_m   [2];
  bit          last_m [2];
  logic [31:0] ma1    [2];
  logic [31:0] ma2    [2];
  logic [3:0]  msel   [2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment ALU; overflow reports add overflow for every opcode except sub.
  function automatic logic [32:0] alu_f(input logic [3:0] s, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] sum;
    logic [31:0] dif;
    logic [31:0] r;
    logic        ov;
    sum = a + b;
    dif = a - b;
    ov  = (a[31] == b[31]) && (sum[31] != a[31]);
    case (s)
      4'd0:    r = a & b;
      4'd1:    r = a | b;
      4'd2:    r = a ^ b;
      4'd3:    r = ~a;
      4'd4:    r = a << b[4:0];
      4'd5:    r = sum;
      4'd6:    r = a >> b[4:0];
      4'd7:    begin r = dif; ov = (a[31] != b[31]) && (dif[31] != a[31]); end
      4'd8:    r = {31'd0, ($signed(a) < $signed(b))};
      4'd9:    r = a * b;
      4'd10:   r = ~(a | b);
      default: r = 32'h0;
    endcase
    return {ov, r};
  endfunction

  always_comb {alu_overflow[0], alu_result[0]} = alu_f(alu_sel[0], alu_inp_1[0], alu_inp_2[0]);
  always_comb {alu_overflow[1], alu_result[1]} = alu_f(alu_sel[1], alu_inp_1[1], alu_inp_2[1]);

  alu_arbiter #(.RR_EN(1)) u_rr (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid[0]), .req0_ready(req0_ready[0]),
    .req0_inp_1(req0_inp_1[0]), .req0_inp_2(req0_inp_2[0]), .req0_sel(req0_sel[0]),
    .req1_valid(req1_valid[0]), .req1_ready(req1_ready[0]),
    .req1_inp_1(req1_inp_1[0]), .req1_inp_2(req1_inp_2[0]), .req1_sel(req1_sel[0]),
    .alu_inp_1(alu_inp_1[0]), .alu_inp_2(alu_inp_2[0]), .alu_sel(alu_sel[0]),
    .alu_result(alu_result[0]), .alu_overflow(alu_overflow[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_id(rsp_id[0]),
    .rsp_result(rsp_result[0]), .rsp_overflow(rsp_overflow[0]), .rsp_err(rsp_err[0]),
    .busy(busy[0])
  );

  alu_arbiter #(.RR_EN(0)) u_fp (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid[1]), .req0_ready(req0_ready[1]),
    .req0_inp_1(req0_inp_1[1]), .req0_inp_2(req0_inp_2[1]), .req0_sel(req0_sel[1]),
    .req1_valid(req1_valid[1]), .req1_ready(req1_ready[1]),
    .req1_inp_1(req1_inp_1[1]), .req1_inp_2(req1_inp_2[1]), .req1_sel(req1_sel[1]),
    .alu_inp_1(alu_inp_1[1]), .alu_inp_2(alu_inp_2[1]), .alu_sel(alu_sel[1]),
    .alu_result(alu_result[1]), .alu_overflow(alu_overflow[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_id(rsp_id[1]),
    .rsp_result(rsp_result[1]), .rsp_overflow(rsp_overflow[1]), .rsp_err(rsp_err[1]),
    .busy(busy[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_reset(input int k);
    check("rst_ready0", req0_ready[k], 0);
    check("rst_ready1", req1_ready[k], 0);
    check("rst_rsp_valid", rsp_valid[k], 0);
    check("rst_rsp_id", rsp_id[k], 0);
    check("rst_rsp_result", rsp_result[k], 0);
    check("rst_rsp_ovf", rsp_overflow[k], 0);
    check("rst_rsp_err", rsp_err[k], 0);
    check("rst_busy", busy[k], 0);
    check("rst_alu_a", alu_inp_1[k], 0);
    check("rst_alu_b", alu_inp_2[k], 0);
    check("rst_alu_sel", alu_sel[k], 0);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      last_m[k] = 1'b1;
      ma1[k] = '0;
      ma2[k] = '0;
      msel[k] = '0;
    end
  endtask

  task automatic chk_alu(input int k);
    check("alu_a_hold", alu_inp_1[k], ma1[k]);
    check("alu_b_hold", alu_inp_2[k], ma2[k]);
    check("alu_sel_hold", alu_sel[k], msel[k]);
  endtask

  task automatic chk_resp(input int k, input bit w, input logic [31:0] er, input bit eo, input bit ee);
    check("rsp_valid", rsp_valid[k], 1);
    check("rsp_id", rsp_id[k], w);
    check("rsp_result", rsp_result[k], er);
    check("rsp_overflow", rsp_overflow[k], eo);
    check("rsp_err", rsp_err[k], ee);
    check("resp_busy", busy[k], 1);
    check("resp_ready0", req0_ready[k], 0);
    check("resp_ready1", req1_ready[k], 0);
    chk_alu(k);
  endtask

  // One full transaction; the loser (if any) keeps its request raised until the response completes.
  task automatic txn(input int k, input bit v0, input bit v1, input int hold, input bit early);
    bit          w;
    bit          legal;
    bit          eo;
    logic [31:0] ea, eb, er;
    logic [3:0]  es;
    logic [32:0] ex;
    @(negedge clk);
    req0_valid[k] = v0;
    req1_valid[k] = v1;
    rsp_ready[k]  = early;
    #1;
    if (!v0 && !v1) begin
      check("idle_ready0", req0_ready[k], 0);
      check("idle_ready1", req1_ready[k], 0);
      check("idle_busy", busy[k], 0);
      check("idle_rsp_valid", rsp_valid[k], 0);
      rsp_ready[k] = 1'b0;
      return;
    end
    w = (v0 && v1) ? (rr_m[k] && !last_m[k]) : v1;
    check("grant_ready0", req0_ready[k], !w);
    check("grant_ready1", req1_ready[k], w);
    check("grant_busy", busy[k], 0);
    check("grant_rsp_valid", rsp_valid[k], 0);
    ea = w ? req1_inp_1[k] : req0_inp_1[k];
    eb = w ? req1_inp_2[k] : req0_inp_2[k];
    es = w ? req1_sel[k]   : req0_sel[k];
    legal = (es <= 4'd10);
    ex = alu_f(es, ea, eb);
    er = legal ? ex[31:0] : 32'h0;
    eo = legal && ((es == 4'd5) || (es == 4'd7)) && ex[32];
    @(negedge clk);
    if (w) req1_valid[k] = 1'b0;
    else   req0_valid[k] = 1'b0;
    if (legal) begin
      ma1[k] = ea;
      ma2[k] = eb;
      msel[k] = es;
      #1;
      check("exec_busy", busy[k], 1);
      check("exec_rsp_valid", rsp_valid[k], 0);
      check("exec_ready0", req0_ready[k], 0);
      check("exec_ready1", req1_ready[k], 0);
      chk_alu(k);
      @(negedge clk);
    end
    #1;
    chk_resp(k, w, er, eo, !legal);
    if (!early) begin
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        #1;
        chk_resp(k, w, er, eo, !legal);
      end
      rsp_ready[k] = 1'b1;
    end
    @(negedge clk);
    rsp_ready[k]  = 1'b0;
    req0_valid[k] = 1'b0;
    req1_valid[k] = 1'b0;
    #1;
    check("done_rsp_valid", rsp_valid[k], 0);
    check("done_busy", busy[k], 0);
    last_m[k] = w;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h7FFF_FFFF;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic rand_payload(input int k, input bit legal_only);
    req0_inp_1[k] = pick();
    req0_inp_2[k] = pick();
    req1_inp_1[k] = pick();
    req1_inp_2[k] = pick();
    req0_sel[k] = legal_only ? 4'($urandom_range(0, 10)) : 4'($urandom_range(0, 15));
    req1_sel[k] = legal_only ? 4'($urandom_range(0, 10)) : 4'($urandom_range(0, 15));
  endtask

  // Both requesters held valid across back-to-back transactions; records the grant order.
  task automatic rr_run(input int k);
    bit prev;
    bit g;
    bit r1_seen;
    int n;
    int cyc;
    rand_payload(k, 1'b1);
    @(negedge clk);
    req0_valid[k] = 1'b1;
    req1_valid[k] = 1'b1;
    rsp_ready[k]  = 1'b1;
    prev = last_m[k];
    n = 0;
    cyc = 0;
    r1_seen = 1'b0;
    while (n < 4 && cyc < 60) begin
      #1;
      if (req1_ready[k]) r1_seen = 1'b1;
      if (req0_ready[k] || req1_ready[k]) begin
        g = req1_ready[k];
        check("order_grant", g, rr_m[k] && !prev);
        prev = g;
        n++;
      end
      @(negedge clk);
      cyc++;
    end
    check("order_count", n, 4);
    if (!rr_m[k]) check("order_ready1_seen", r1_seen, 0);
    req0_valid[k] = 1'b0;
    req1_valid[k] = 1'b0;
    cyc = 0;
    #1;
    while (busy[k] && cyc < 10) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    check("order_drain_busy", busy[k], 0);
    rsp_ready[k] = 1'b0;
    last_m[k] = prev;
    ma1[k]  = prev ? req1_inp_1[k] : req0_inp_1[k];
    ma2[k]  = prev ? req1_inp_2[k] : req0_inp_2[k];
    msel[k] = prev ? req1_sel[k]   : req0_sel[k];
    chk_alu(k);
  endtask

  initial begin
    rr_m[0] = 1'b1;
    rr_m[1] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      req0_valid[k] = 0; req1_valid[k] = 0; rsp_ready[k] = 0;
      req0_inp_1[k] = 0; req0_inp_2[k] = 0; req0_sel[k] = 0;
      req1_inp_1[k] = 0; req1_inp_2[k] = 0; req1_sel[k] = 0;
    end
    model_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk_reset(0);
    chk_reset(1);
    @(negedge clk);
    rst_n = 1'b1;

    // Fresh after reset: contested grants start with requester 0
    rr_run(0);
    rr_run(1);

    // 5 + 7 with add opcode
    req0_inp_1[0] = 32'd5; req0_inp_2[0] = 32'd7; req0_sel[0] = 4'b0101;
    txn(0, 1, 0, 0, 1);
    // Signed overflow on add, then same operands with an opcode that masks overflow
    req1_inp_1[0] = 32'h7FFF_FFFF; req1_inp_2[0] = 32'd1; req1_sel[0] = 4'b0101;
    txn(0, 0, 1, 0, 1);
    req1_sel[0] = 4'b0011;
    txn(0, 0, 1, 0, 1);
    // Illegal opcode: error response, ALU inputs untouched
    req0_inp_1[0] = 32'hDEAD_BEEF; req0_inp_2[0] = 32'h1234_5678; req0_sel[0] = 4'b1100;
    txn(0, 1, 0, 0, 0);
    // Response back-pressure for 5 cycles with both requesters pending
    rand_payload(0, 1'b1);
    txn(0, 1, 1, 5, 0);

    // Asynchronous reset while a transaction is in EXEC
    @(negedge clk);
    req0_inp_1[0] = 32'h1111_1111; req0_inp_2[0] = 32'h2222_2222; req0_sel[0] = 4'b0101;
    req0_valid[0] = 1'b1;
    #1 check("mid_accept", req0_ready[0], 1);
    @(negedge clk);
    req0_valid[0] = 1'b0;
    #1 check("mid_exec_busy", busy[0], 1);
    #2 rst_n = 1'b0;
    #1;
    chk_reset(0);
    chk_reset(1);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      check("post_rst_rsp_valid", rsp_valid[0], 0);
      check("post_rst_busy", busy[0], 0);
    end

    // Randomized traffic on both instances
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 150; i++) begin
        rand_payload(k, 1'b0);
        txn(k, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
